reg_seq_ctl: RTL

REG_SEQ_CTL -- requirements
Module: reg_seq_ctl

---
 rtl/torch_reg_pkg.sv | 28 ++
 rtl/reg_seq_cell.sv | 38 +++
 rtl/reg_seq_ctl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/torch_reg_pkg.sv
// ============================================================================
//  torch_reg_pkg
//  Shared constants, index-width helper and FSM state encoding for the
//  register sequencing controller.
//  Rev 1.0
// ============================================================================
`default_nettype none

package torch_reg_pkg;

    localparam int NREG_DEF        = 32;
    localparam int RECOVER_CYC_DEF = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_w(NREG_DEF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BOOSTED = 2'd1,
        ST_RECOVER = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_seq_cell.sv
// ============================================================================
//  reg_seq_cell
//  One architectural register's sequential pointer and boost-valid flag.
//  Rev 1.0
// ============================================================================
`default_nettype none

module reg_seq_cell (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_flip,
    input  logic i_clear,
    input  logic i_set,
    output logic o_seq,
    output logic o_bv
);

    logic r_seq;
    logic r_bv;

    // A set arriving with a clear belongs to the next branch, so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq <= 1'b0;
            r_bv  <= 1'b0;
        end else if (i_en) begin
            r_seq <= r_seq ^ (i_flip & r_bv);
            r_bv  <= (r_bv & ~i_clear) | i_set;
        end
    end

    assign o_seq = r_seq;
    assign o_bv  = r_bv;

endmodule

`default_nettype wire

// File: rtl/reg_seq_ctl.sv
// ============================================================================
//  reg_seq_ctl
//  Boosted-write sequencing: per-register copy selection, commit/squash and
//  exception recovery control for a dual-ported shadowed register file.
//  Rev 1.0
// ============================================================================
`default_nettype none

module reg_seq_ctl
    import torch_reg_pkg::*;
#(
    parameter  int NREG        = NREG_DEF,
    parameter  int RECOVER_CYC = RECOVER_CYC_DEF,
    localparam int IW          = idx_w(NREG)
) (
    input  logic          Phi1,
    input  logic          Reset_s1,
    input  logic          Stall_s1,
    input  logic          Except_s1,
    input  logic          Commit_s1,
    input  logic          Squash_s1,
    input  logic          AWr_s1,
    input  logic          BWr_s1,
    input  logic [IW-1:0] AWrReg_s1,
    input  logic [IW-1:0] BWrReg_s1,
    input  logic          AWrBoost_s1,
    input  logic          BWrBoost_s1,
    input  logic [IW-1:0] ARdReg_s1,
    input  logic [IW-1:0] BRdReg_s1,
    input  logic          ARdBoost_s1,
    input  logic          BRdBoost_s1,
    output logic          AWrEn_s1,
    output logic          BWrEn_s1,
    output logic          AWrPtr_s1,
    output logic          BWrPtr_s1,
    output logic          ARdPtr_s1,
    output logic          BRdPtr_s1,
    output logic          BoostAny_s1,
    output logic          Busy_s1
);

    localparam int c_CW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(RECOVER_CYC - 1);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;

    logic [NREG-1:0] w_seq;
    logic [NREG-1:0] w_bv;
    logic [NREG-1:0] w_set;

    logic w_blk, w_a_ok, w_b_ok, w_clash, w_boost_wr;
    logic w_adv, w_live, w_clear, w_flip;

    assign w_blk   = Reset_s1 | Stall_s1 | Except_s1 | (r_state == ST_RECOVER);
    assign w_a_ok  = AWr_s1 & ~w_blk & (AWrReg_s1 != '0);
    assign w_b_ok  = BWr_s1 & ~w_blk & (BWrReg_s1 != '0);
    // Same register, same copy: port B's data is the one that lands.
    assign w_clash = AWr_s1 & BWr_s1 & (AWrReg_s1 == BWrReg_s1)
                   & (AWrBoost_s1 == BWrBoost_s1);

    assign AWrEn_s1  = w_a_ok & ~w_clash;
    assign BWrEn_s1  = w_b_ok;
    assign AWrPtr_s1 = w_seq[AWrReg_s1] ^ AWrBoost_s1;
    assign BWrPtr_s1 = w_seq[BWrReg_s1] ^ BWrBoost_s1;
    assign ARdPtr_s1 = w_seq[ARdReg_s1] ^ (ARdBoost_s1 & w_bv[ARdReg_s1]);
    assign BRdPtr_s1 = w_seq[BRdReg_s1] ^ (BRdBoost_s1 & w_bv[BRdReg_s1]);

    assign w_boost_wr = (AWrEn_s1 & AWrBoost_s1) | (BWrEn_s1 & BWrBoost_s1);
    assign w_adv      = Except_s1 | ~Stall_s1;
    assign w_live     = (r_state != ST_RECOVER) & ~Except_s1;
    assign w_clear    = Except_s1 | (w_live & (Commit_s1 | Squash_s1));
    assign w_flip     = w_live & Commit_s1 & ~Squash_s1;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cell
            assign w_set[gi] = (AWrEn_s1 & AWrBoost_s1 & (AWrReg_s1 == IW'(gi)))
                             | (BWrEn_s1 & BWrBoost_s1 & (BWrReg_s1 == IW'(gi)));

            reg_seq_cell u_cell (
                .clk     (Phi1),
                .rst     (Reset_s1),
                .i_en    (w_adv),
                .i_flip  (w_flip),
                .i_clear (w_clear),
                .i_set   (w_set[gi]),
                .o_seq   (w_seq[gi]),
                .o_bv    (w_bv[gi])
            );
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (Except_s1) begin
            w_state_nxt = ST_RECOVER;
            w_cnt_nxt   = c_CNT_LOAD;
        end else if (!Stall_s1) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_boost_wr) w_state_nxt = ST_BOOSTED;
                end
                ST_BOOSTED: begin
                    if ((Commit_s1 | Squash_s1) & ~w_boost_wr) w_state_nxt = ST_IDLE;
                end
                ST_RECOVER: begin
                    if (r_cnt == '0) w_state_nxt = ST_IDLE;
                    else             w_cnt_nxt   = r_cnt - c_CW'(1);
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Phi1) begin
        if (Reset_s1) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign BoostAny_s1 = (r_state == ST_BOOSTED);
    assign Busy_s1     = (r_state == ST_RECOVER);

endmodule

`default_nettype wire
